// File: rtl/ppm_pkg.sv
// Shared definitions for the PPM pulse-width decoder and its encoder counterpart.
// Holds the FSM state type, the code width and the default pulse limits.
package ppm_pkg;

  localparam int CODE_W = 16;

  localparam logic [15:0] DEF_MIN_WIDTH      = 16'd1;
  localparam logic [15:0] DEF_MAX_WIDTH      = 16'd65534;
  localparam logic [23:0] DEF_TIMEOUT_CYCLES = 24'd200000;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  // A measured width is reportable when it lies inside the accepted window.
  function automatic logic width_ok(input logic [CODE_W-1:0] width,
                                    input logic [CODE_W-1:0] lo,
                                    input logic [CODE_W-1:0] hi);
    return (width >= lo) && (width <= hi);
  endfunction

endpackage

// File: rtl/ppm_sync_edge.sv
// Brings the asynchronous pulse pin into the clock domain and derives
// single-cycle rise/fall indications from the synchronized level.
module ppm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ppm,
  output logic ppm_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   ppm_d;

  // Synchronizer chain plus one delay flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      ppm_d <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], ppm};
      ppm_d <= sync[SYNC_STAGES-1];
    end
  end

  assign ppm_s = sync[SYNC_STAGES-1];
  assign rise  = ppm_s & ~ppm_d;
  assign fall  = ~ppm_s & ppm_d;

endmodule

// File: rtl/ppm2code.sv
// Pulse-width decoder: a pin-level high time of N clock cycles is reported as
// CODE = N with a VALID strobe; out-of-window pulses give ERR, silence gives LOST.
module ppm2code
  import ppm_pkg::*;
#(
  parameter int          SYNC_STAGES    = 2,
  parameter logic [15:0] MIN_WIDTH      = DEF_MIN_WIDTH,
  parameter logic [15:0] MAX_WIDTH      = DEF_MAX_WIDTH,
  parameter logic [23:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PPM,
  output logic [CODE_W-1:0] CODE,
  output logic              VALID,
  output logic              ERR,
  output logic              LOST
);

  localparam logic [CODE_W-1:0] SETTLE = CODE_W'(SYNC_STAGES);

  state_t            state;
  logic [CODE_W-1:0] width;
  logic [23:0]       tmo_cnt;
  logic              ppm_s;
  logic              rise;
  logic              fall;
  logic              valid_evt;

  ppm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (CLK),
    .rst  (RST),
    .ppm  (PPM),
    .ppm_s(ppm_s),
    .rise (rise),
    .fall (fall)
  );

  assign valid_evt = (state == ST_HIGH) && fall && width_ok(width, MIN_WIDTH, MAX_WIDTH);

  // Pulse measurement FSM. In ARM the width counter doubles as a settle timer so
  // the reset-cleared synchronizer cannot fake a low level and admit a partial pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_ARM;
      width <= '0;
      CODE  <= '0;
      VALID <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      VALID <= 1'b0;
      ERR   <= 1'b0;
      case (state)
        ST_ARM: begin
          if (width < SETTLE) begin
            width <= width + 16'd1;
          end else if (!ppm_s) begin
            state <= ST_IDLE;
            width <= '0;
          end else begin
            state <= ST_ARM;
          end
        end
        ST_IDLE: begin
          if (rise) begin
            state <= ST_HIGH;
            width <= 16'd1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            if (valid_evt) begin
              CODE  <= width;
              VALID <= 1'b1;
            end else begin
              ERR <= 1'b1;
            end
            state <= ST_IDLE;
          end else if (width >= MAX_WIDTH) begin
            state <= ST_OVER;
          end else begin
            width <= width + 16'd1;
          end
        end
        ST_OVER: begin
          if (fall) begin
            ERR   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            state <= ST_OVER;
          end
        end
        default: begin
          state <= ST_ARM;
          width <= '0;
        end
      endcase
    end
  end

  // Loss-of-signal timer; LOST is sticky from reset until the first accepted pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_cnt <= '0;
      LOST    <= 1'b1;
    end else if (valid_evt) begin
      tmo_cnt <= '0;
      LOST    <= 1'b0;
    end else if (tmo_cnt < TIMEOUT_CYCLES) begin
      tmo_cnt <= tmo_cnt + 24'd1;
      if (tmo_cnt + 24'd1 == TIMEOUT_CYCLES) begin
        LOST <= 1'b1;
      end else begin
        LOST <= LOST;
      end
    end else begin
      LOST <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ppm2code.sv
// Randomized bench for ppm2code: a pin-level pulse model predicts every strobe,
// the held code and the loss flag, and is compared against the DUT each cycle.
module tb_ppm2code;

  localparam int SYNC = 2;
  localparam int MINW = 10;
  localparam int MAXW = 2000;
  localparam int TMO  = 5000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ppm;
  logic [15:0] code;
  logic        valid;
  logic        err;
  logic        lost;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int at;
    bit ok;
    int w;
  } ev_t;

  ev_t q[$];
  int  cyc;
  int  run;
  int  since;
  bit  armed;
  bit  ever;
  int  m_code;
  bit  m_valid;
  bit  m_err;
  bit  m_lost;

  ppm2code #(
    .SYNC_STAGES   (SYNC),
    .MIN_WIDTH     (16'd10),
    .MAX_WIDTH     (16'd2000),
    .TIMEOUT_CYCLES(24'd5000)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .PPM  (ppm),
    .CODE (code),
    .VALID(valid),
    .ERR  (err),
    .LOST (lost)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: measures pin-level high runs and schedules the outcome
  // SYNC edges after the first low sample of the pin.
  task automatic model_step();
    ev_t ev;
    if (rst) begin
      q.delete();
      cyc = 0; run = 0; since = 0; armed = 0; ever = 0;
      m_code = 0; m_valid = 0; m_err = 0; m_lost = 1;
    end else begin
      cyc++;
      m_valid = 0;
      m_err   = 0;
      if (q.size() > 0 && q[0].at == cyc) begin
        ev = q.pop_front();
        if (ev.ok) begin
          m_valid = 1;
          m_code  = ev.w;
        end else begin
          m_err = 1;
        end
      end
      if (m_valid) begin
        since = 0;
        ever  = 1;
      end else begin
        since++;
      end
      m_lost = !ever || (since >= TMO);
      if (ppm) begin
        if (armed) run++;
      end else begin
        if (armed && run > 0) begin
          ev.at = cyc + SYNC;
          ev.ok = (run >= MINW) && (run <= MAXW);
          ev.w  = run;
          q.push_back(ev);
        end
        run   = 0;
        armed = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      check_eq("rst_code",  32'(code),  32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_err",   32'(err),   32'd0);
      check_eq("rst_lost",  32'(lost),  32'd1);
    end else begin
      check_eq("valid", 32'(valid), 32'(m_valid));
      check_eq("err",   32'(err),   32'(m_err));
      check_eq("code",  32'(code),  32'(m_code));
      check_eq("lost",  32'(lost),  32'(m_lost));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int w, input int gap);
    ppm = 1'b1;
    tick(w);
    ppm = 1'b0;
    tick(gap);
  endtask

  initial begin
    int w;
    int gap;
    rst = 1'b1;
    ppm = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(10);

    pulse(1000, 20);

    ppm = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(50);
    ppm = 1'b0;
    tick(10);
    pulse(300, 20);

    pulse(5, 20);
    pulse(10, 20);
    pulse(9, 20);

    pulse(2001, 20);
    pulse(2000, 20);

    pulse(50, 5100);
    pulse(700, 20);

    ppm = 1'b1;
    tick(400);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(600);
    ppm = 1'b0;
    tick(20);
    pulse(1000, 20);

    pulse(12, 1);
    pulse(12, 1);
    pulse(1, 1);
    pulse(10, 1);
    pulse(11, 20);

    ppm = 1'b1;
    tick(6000);
    ppm = 1'b0;
    tick(20);

    for (int i = 0; i < 60; i++) begin
      w   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2100)) : int'($urandom_range(1, 40));
      gap = $urandom_range(1, 30);
      if ($urandom_range(0, 15) == 0) begin
        ppm = 1'b1;
        tick(w / 2 + 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(w / 2 + 1);
        ppm = 1'b0;
        tick(gap);
      end else begin
        pulse(w, gap);
      end
    end

    tick(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
